muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 175 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: 32-cycle shift-add multiply and restoring divide on magnitudes, sign fixup in FIX.
// Optional build macro MULDIV_UNIT_FAST_MUL_EN: single-cycle combinational multiply, commit at acceptance.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int DATA_W = 32;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t                  state, state_nxt;
  logic [4:0]              iter_cnt;
  logic [2*DATA_W-1:0]     acc;       // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [DATA_W-1:0]       opb;
  logic                    neg_q, neg_r, div_zero, op_div;
  logic                    accept;
  logic [DATA_W:0]         mul_sum;
  logic [DATA_W:0]         div_diff;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic sgn);
    logic signed [DATA_W-1:0] s;
    s = $signed(v);
    return (sgn && s < 0) ? DATA_W'(-s) : v;
  endfunction

  function automatic logic [DATA_W-1:0] fix32(input logic [DATA_W-1:0] v, input logic neg);
    logic signed [DATA_W-1:0] s;
    s = $signed(v);
    return neg ? DATA_W'(-s) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] fix64(input logic [2*DATA_W-1:0] v, input logic neg);
    logic signed [2*DATA_W-1:0] s;
    s = $signed(v);
    return neg ? (2*DATA_W)'(-s) : v;
  endfunction

`ifdef MULDIV_UNIT_FAST_MUL_EN
  function automatic logic [2*DATA_W-1:0] mul_fast(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b,
                                                   input logic sgn);
    logic signed [2*DATA_W-1:0] sa, sb;
    sa = $signed({{DATA_W{sgn & a[DATA_W-1]}}, a});
    sb = $signed({{DATA_W{sgn & b[DATA_W-1]}}, b});
    return (2*DATA_W)'(sa * sb);
  endfunction
`endif

  assign accept   = start && (state == IDLE) && (op != 3'b110) && (op != 3'b111);
  assign busy     = (state != IDLE);
  assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, (acc[0] ? opb : {DATA_W{1'b0}})};
  assign div_diff = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]} - {1'b0, opb};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (op == OP_DIV || op == OP_DIVU) begin
            state_nxt = DIV;
          end else if (op == OP_MULT || op == OP_MULTU) begin
`ifdef MULDIV_UNIT_FAST_MUL_EN
            state_nxt = IDLE;
`else
            state_nxt = MUL;
`endif
          end
        end
      end
      MUL:     if (iter_cnt == 5'd31) state_nxt = FIX;
      DIV:     if (iter_cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      iter_cnt <= '0;
      acc      <= '0;
      opb      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      op_div   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        // acceptance: capture magnitudes and sign info, or commit single-cycle ops
        IDLE: begin
          if (accept) begin
            iter_cnt <= '0;
            case (op)
              OP_MTHI: begin
                hi   <= rs_data;
                done <= 1'b1;
              end
              OP_MTLO: begin
                lo   <= rs_data;
                done <= 1'b1;
              end
              OP_MULT, OP_MULTU: begin
`ifdef MULDIV_UNIT_FAST_MUL_EN
                {hi, lo} <= mul_fast(rs_data, rt_data, ~op[0]);
                done     <= 1'b1;
`else
                acc    <= {{DATA_W{1'b0}}, mag(rt_data, ~op[0])};
                opb    <= mag(rs_data, ~op[0]);
                neg_q  <= ~op[0] & (rs_data[DATA_W-1] ^ rt_data[DATA_W-1]);
                neg_r  <= 1'b0;
                op_div <= 1'b0;
`endif
              end
              OP_DIV, OP_DIVU: begin
                acc      <= {{DATA_W{1'b0}}, mag(rs_data, ~op[0])};
                opb      <= mag(rt_data, ~op[0]);
                neg_q    <= ~op[0] & (rs_data[DATA_W-1] ^ rt_data[DATA_W-1]);
                neg_r    <= ~op[0] & rs_data[DATA_W-1];
                div_zero <= (rt_data == '0);
                op_div   <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        // iteration: one shift-add step per cycle
        MUL: begin
          acc      <= {mul_sum, acc[DATA_W-1:1]};
          iter_cnt <= iter_cnt + 5'd1;
        end
        // iteration: one restoring-division step per cycle
        DIV: begin
          if (!div_diff[DATA_W])
            acc <= {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
          else
            acc <= {acc[2*DATA_W-2:0], 1'b0};
          iter_cnt <= iter_cnt + 5'd1;
        end
        // fixup and commit
        FIX: begin
          if (op_div) begin
            lo <= div_zero ? {DATA_W{1'b1}} : fix32(acc[DATA_W-1:0], neg_q);
            hi <= fix32(acc[2*DATA_W-1:DATA_W], neg_r);
          end else begin
            {hi, lo} <= fix64(acc, neg_q);
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized and directed bench for muldiv_unit against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

`ifdef MULDIV_UNIT_FAST_MUL_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 33;
`endif

  muldiv_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint          sp;
    longint unsigned up, ua, ub;
    if (sgn) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      return sp;
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    up = ua * ub;
    return up;
  endfunction

  // returns {HI, LO} = {remainder, quotient}
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint      sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      qv = q;
      rv = r;
      return {rv[31:0], qv[31:0]};
    end
    return {a % b, a / b};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Called in the low phase of clk; returns at a negedge. intr >= 0 injects an MTLO start mid-flight.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int intr);
    int          cyc, bcnt, exp_lat;
    bit          hold_ok;
    logic [63:0] r;
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    @(posedge clk);
    #1;
    start   = 1'b0;
    rs_data = $urandom;
    rt_data = $urandom;
    op      = 3'($urandom_range(0, 7));
    case (o)
      3'd0:    r = ref_mul(a, b, 1'b1);
      3'd1:    r = ref_mul(a, b, 1'b0);
      3'd2:    r = ref_div(a, b, 1'b1);
      3'd3:    r = ref_div(a, b, 1'b0);
      3'd4:    r = {a, m_lo};
      default: r = {m_hi, a};
    endcase
    exp_lat = (o >= 3'd4) ? 0 : (o < 3'd2) ? MUL_LAT : 33;
    cyc = 0;
    bcnt = 0;
    hold_ok = 1'b1;
    @(negedge clk);
    while (!done && cyc < 60) begin
      if (busy) bcnt++;
      if (hi !== m_hi || lo !== m_lo) hold_ok = 1'b0;
      if (cyc == intr) begin
        start   = 1'b1;
        op      = 3'b101;
        rs_data = 32'h0000_1234;
      end else begin
        start = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    m_hi = r[63:32];
    m_lo = r[31:0];
    chk({tag, "_done_seen"}, 64'(cyc < 60), 64'(1));
    chk({tag, "_busy_cycles"}, 64'(bcnt), 64'(exp_lat));
    chk({tag, "_hold"}, 64'(hold_ok), 64'(1));
    chk({tag, "_hi"}, 64'(hi), 64'(m_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(m_lo));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'({busy, done}), 64'(0));
  endtask

  task automatic reserved_op(input logic [2:0] o);
    start   = 1'b1;
    op      = o;
    rs_data = $urandom;
    rt_data = $urandom;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk($sformatf("rsv%0d_ctl", o), 64'({busy, done}), 64'(0));
    chk($sformatf("rsv%0d_hilo", o), {hi, lo}, {m_hi, m_lo});
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          no_done;
    logic [2:0]  o;
    #1 rst = 1'b1;
    #1;
    chk("reset_ctl", 64'({busy, done}), 64'(0));
    chk("reset_hilo", {hi, lo}, 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
    chk("multu_max_exact", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    do_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'h0000_0007, -1);
    chk("mult_neg_exact", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    do_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'h0000_0002, -1);
    chk("div_neg_exact", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op("divu_zero", 3'd3, 32'h0000_0064, 32'h0000_0000, -1);
    chk("divu_zero_exact", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    chk("div_ovf_exact", {hi, lo}, 64'h0000_0000_8000_0000);
    do_op("div_zero_s", 3'd2, 32'h8000_0005, 32'h0000_0000, -1);

    do_op("divu_intr", 3'd3, 32'd100, 32'd7, 4);
    chk("divu_intr_exact", {hi, lo}, {32'd2, 32'd14});
    do_op("mtlo", 3'd5, 32'h0000_1234, 32'h0, -1);
    chk("mtlo_exact", {hi, lo}, {32'd2, 32'h0000_1234});

    reserved_op(3'd6);
    reserved_op(3'd7);

    // reset in the middle of a divide
    do_op("mthi", 3'd4, 32'hAAAA_5555, 32'h0, -1);
    start   = 1'b1;
    op      = 3'd3;
    rs_data = 32'd100;
    rt_data = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_ctl", 64'({busy, done}), 64'(0));
    chk("midrst_hilo", {hi, lo}, 64'(0));
    m_hi = '0;
    m_lo = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    no_done = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) no_done = 1'b0;
    end
    chk("midrst_no_done", 64'(no_done), 64'(1));

    // acceptance at the first edge after reset release
    rst = 1'b1;
    #2 rst = 1'b0;
    do_op("post_rst_mtlo", 3'd5, 32'hCAFE_F00D, 32'h0, -1);
    do_op("post_rst_div", 3'd2, 32'h7FFF_FFFF, 32'hFFFF_FFF0, -1);

    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 5));
      do_op($sformatf("rnd%0d_op%0d", i, o), o, pick(), pick(), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
